imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory the CPU fetches from. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It issues one write per word into the instruction RAM and holds the CPU in reset until a complete frame with a correct checksum has been written.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 21 ++
 rtl/imem_loader_word_assembler.sv | 33 +++
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } loader_state_t;

    localparam int CNT_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction RAM write port of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 5
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler; the fourth byte is merged combinationally
// so the completed word is available in the same cycle as word_complete.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_idx;
    logic [23:0] word_q;

    assign word_complete = shift_en && (byte_idx == LAST_IDX);
    assign word          = {byte_in, word_q};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (shift_en) begin
            byte_idx <= byte_idx + 2'd1;
            word_q   <= {byte_in, word_q[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction RAM; holds the CPU in reset
// until a whole frame with a matching XOR checksum has been written.
//
// state    | meaning
// S_CNT_LO | waiting for low byte of the word count
// S_CNT_HI | waiting for high byte; count is range-checked here
// S_DATA   | receiving payload bytes, one RAM write per 4 bytes
// S_CSUM   | waiting for checksum byte
// S_DONE   | frame verified, CPU released (terminal until restart)
// S_ERROR  | frame rejected, CPU held (terminal until restart)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    input  logic          restart,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    localparam int                CNT_W   = 8 * CNT_BYTES;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_W   = (ADDR_W + 1)'(1);

    loader_state_t     state;
    logic              in_ready_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              error_q;

    logic [7:0]        cnt_lo;
    logic [ADDR_W:0]   cnt_last;
    logic [ADDR_W:0]   word_idx;
    logic [7:0]        csum;

    logic              xfer;
    logic [CNT_W-1:0]  n_cnt;
    logic              asm_clear;
    logic              asm_shift;
    logic [31:0]       asm_word;
    logic              asm_complete;

    assign xfer      = bus.in_valid && in_ready_q;
    assign n_cnt     = {bus.in_data, cnt_lo};
    assign asm_clear = xfer && (state == S_CNT_HI);
    assign asm_shift = xfer && (state == S_DATA);

    word_assembler u_word_assembler (
        .clk           (clk),
        .reset         (reset),
        .clear         (asm_clear),
        .shift_en      (asm_shift),
        .byte_in       (bus.in_data),
        .word          (asm_word),
        .word_complete (asm_complete)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CNT_LO;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cnt_lo     <= '0;
            cnt_last   <= '0;
            word_idx   <= '0;
            csum       <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                S_CNT_LO: begin
                    if (xfer) begin
                        cnt_lo <= bus.in_data;
                        state  <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (xfer) begin
                        if (n_cnt == '0 || n_cnt > DEPTH_C) begin
                            state      <= S_ERROR;
                            error_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else begin
                            state    <= S_DATA;
                            cnt_last <= n_cnt[ADDR_W:0] - ONE_W;
                            word_idx <= '0;
                            csum     <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum <= csum ^ bus.in_data;
                        if (asm_complete) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= word_idx[ADDR_W-1:0];
                            wr_data_q <= asm_word;
                            word_idx  <= word_idx + ONE_W;
                            if (word_idx == cnt_last) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        if (bus.in_data == csum) begin
                            state      <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state   <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (restart) begin
                        state      <= S_CNT_LO;
                        in_ready_q <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                default: begin
                    state <= S_CNT_LO;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: RAM writes are scoreboarded against
// expectations queued when each frame is sent.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic restart = 1'b0;
    logic cpu_hold, done, error;

    imem_loader_if #(.ADDR_W(5)) bus ();

    imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .restart  (restart),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          n_total = 0;
    int          n_bad = 0;
    int          wr_count = 0;
    wr_t         sb_q[$];
    wr_t         mon_e;
    logic [31:0] frame_words[32];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_count++;
            if (sb_q.size() == 0) begin
                check_val("wr_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("wr_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
                check_val("wr_data", bus.wr_data, mon_e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (bus.in_ready !== 1'b1) check_val("ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] csum_mask, input int max_gap);
        logic [7:0] csum;
        logic [7:0] b;
        csum = 8'h00;
        send_byte(8'(n), 0);
        send_byte(8'(n >> 8), 0);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{addr: 5'(i), data: frame_words[i]});
            for (int k = 0; k < 4; k++) begin
                b = frame_words[i][8*k +: 8];
                csum = csum ^ b;
                send_byte(b, int'($urandom_range(0, max_gap)));
            end
        end
        send_byte(csum ^ csum_mask, int'($urandom_range(0, max_gap)));
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic check_status(input string pfx, input logic rdy, input logic hold,
                                input logic dn, input logic err);
        check_val({pfx, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
        check_val({pfx, ".cpu_hold"}, 32'(cpu_hold), 32'(hold));
        check_val({pfx, ".done"}, 32'(done), 32'(dn));
        check_val({pfx, ".error"}, 32'(error), 32'(err));
    endtask

    task automatic check_reset_values(input string pfx);
        check_status(pfx, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val({pfx, ".wr_en"}, 32'(bus.wr_en), 32'd0);
        check_val({pfx, ".wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check_val({pfx, ".wr_data"}, bus.wr_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // single word, literal stream
        sb_q.push_back('{addr: 5'd0, data: 32'h005303B3});
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hB3, 0);
        send_byte(8'h03, 0);
        send_byte(8'h53, 0);
        send_byte(8'h00, 0);
        send_byte(8'hE3, 0);
        check_status("single", 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("single.n_wr", 32'(wr_count), 32'd1);
        check_val("single.hold_addr", 32'(bus.wr_addr), 32'd0);
        check_val("single.hold_data", bus.wr_data, 32'h005303B3);

        // restart, restart ignored mid-frame
        pulse_restart();
        check_status("restart", 1'b1, 1'b1, 1'b0, 1'b0);
        sb_q.push_back('{addr: 5'd0, data: 32'hDEADBEEF});
        send_byte(8'h01, 0);
        send_byte(8'h00, 1);
        send_byte(8'hEF, 0);
        pulse_restart();
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 2);
        send_byte(8'hDE, 0);
        send_byte(8'h22, 0);
        check_status("restart_frame", 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("restart.n_wr", 32'(wr_count), 32'd2);

        // count zero
        pulse_restart();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_status("cnt0", 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("cnt0.n_wr", 32'(wr_count), 32'd2);

        // count above depth
        pulse_restart();
        check_status("cnt33_pre", 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'h21, 0);
        send_byte(8'h00, 0);
        check_status("cnt33", 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("cnt33.n_wr", 32'(wr_count), 32'd2);

        // bad checksum: correct value E3 masked to 00
        pulse_restart();
        frame_words[0] = 32'h005303B3;
        send_frame(1, 8'hE3, 0);
        check_status("badcsum", 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("badcsum.n_wr", 32'(wr_count), 32'd3);

        // full depth with gaps
        pulse_restart();
        for (int i = 0; i < 32; i++) frame_words[i] = 32'(i) * 32'h01010101;
        send_frame(32, 8'h00, 3);
        check_status("full", 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_val("full.n_wr", 32'(wr_count), 32'd35);
        check_val("full.last_addr", 32'(bus.wr_addr), 32'd31);
        check_val("full.last_data", bus.wr_data, 32'h1F1F1F1F);
        check_val("full.sb_left", 32'(sb_q.size()), 32'd0);

        // reset after two payload bytes
        pulse_restart();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("midrst");
        frame_words[0] = 32'hCAFEF00D;
        send_frame(1, 8'h00, 2);
        check_status("post_rst", 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("post_rst.n_wr", 32'(wr_count), 32'd36);
        check_val("post_rst.sb_left", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
